// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - shared FSM encoding, digit/field map and segment constants
package watch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_STORE
  } state_t;

  localparam int NUM_DIGITS = 6;
  localparam int NUM_FIELDS = 6;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [2:0] FIELD_YEAR   = 3'd0;
  localparam logic [2:0] FIELD_MONTH  = 3'd1;
  localparam logic [2:0] FIELD_DAY    = 3'd2;
  localparam logic [2:0] FIELD_HOUR   = 3'd3;
  localparam logic [2:0] FIELD_MINUTE = 3'd4;
  localparam logic [2:0] FIELD_SECOND = 3'd5;

  localparam logic [2:0] PAGE_DATE_BASE = FIELD_YEAR;
  localparam logic [2:0] PAGE_TIME_BASE = FIELD_HOUR;

  // Two digits per field: digit pairs (0,1), (2,3), (4,5) map to consecutive fields of the page.
  function automatic logic [2:0] digit_field(input logic [2:0] idx, input logic page);
    return (page ? PAGE_TIME_BASE : PAGE_DATE_BASE) + {1'b0, idx[2:1]};
  endfunction

endpackage

// File: rtl/watch_bcd_scan_if.sv
// rtl/watch_bcd_scan_if.sv - time-field inputs and multiplexed display outputs
interface watch_bcd_scan_if;
  logic       clk1sec;
  logic [7:0] year;
  logic [7:0] month;
  logic [7:0] day;
  logic [7:0] hour;
  logic [7:0] minute;
  logic [7:0] second;
  logic       page;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       busy;

  modport master (
    output clk1sec, year, month, day, hour, minute, second, page,
    input  seg, dp, an, busy
  );

  modport slave (
    input  clk1sec, year, month, day, hour, minute, second, page,
    output seg, dp, an, busy
  );
endinterface

// File: rtl/watch_seg7_dec.sv
// rtl/watch_seg7_dec.sv - BCD digit to active-low {g,f,e,d,c,b,a} segments
module watch_seg7_dec (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  import watch_pkg::*;

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/watch_bcd_scan.sv
// rtl/watch_bcd_scan.sv - double-dabble time conversion and 6-digit display scanner
module watch_bcd_scan #(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic              clk,
  input  logic              rst,
  watch_bcd_scan_if.slave   bus
);
  import watch_pkg::*;

  state_t      state_q, state_d;
  logic        pending;
  logic [47:0] snap;
  logic [11:0] bcd, bcd_adj;
  logic [2:0]  bit_cnt, fld;
  logic [7:0]  shadow [NUM_FIELDS];
  logic [7:0]  disp   [NUM_FIELDS];
  logic [15:0] div;
  logic [2:0]  idx;
  logic [2:0]  sel_field;
  logic [3:0]  sel_digit;
  logic [6:0]  seg_dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.clk1sec || pending) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: if (bit_cnt == 3'd7) state_d = ST_STORE;
      ST_STORE: state_d = (fld == 3'(NUM_FIELDS - 1)) ? ST_IDLE : ST_SHIFT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int n = 0; n < 3; n++)
      if (bcd[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
  end

  assign bus.busy = (state_q != ST_IDLE);

  // The snapshot shifts MSB-first into the BCD register, so after 8 shifts the next field sits on top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b1;
      snap    <= '0;
      bcd     <= '0;
      bit_cnt <= '0;
      fld     <= '0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
        shadow[i] <= '0;
        disp[i]   <= '0;
      end
    end else begin
      if (state_q == ST_IDLE && state_d == ST_LOAD) pending <= 1'b0;
      else if (bus.clk1sec)                         pending <= 1'b1;

      case (state_q)
        ST_LOAD: begin
          snap    <= {bus.year, bus.month, bus.day, bus.hour, bus.minute, bus.second};
          bcd     <= '0;
          bit_cnt <= '0;
          fld     <= '0;
        end
        ST_SHIFT: begin
          {bcd, snap} <= {bcd_adj, snap} << 1;
          bit_cnt     <= bit_cnt + 3'd1;
        end
        ST_STORE: begin
          shadow[fld] <= bcd[7:0];
          bcd         <= '0;
          fld         <= fld + 3'd1;
          if (state_d == ST_IDLE)
            for (int i = 0; i < NUM_FIELDS; i++)
              disp[i] <= (i == NUM_FIELDS - 1) ? bcd[7:0] : shadow[i];
        end
        default: ;
      endcase
    end
  end

  assign sel_field = digit_field(idx, bus.page);
  assign sel_digit = idx[0] ? disp[sel_field][3:0] : disp[sel_field][7:4];

  watch_seg7_dec u_dec (
    .bcd (sel_digit),
    .seg (seg_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div     <= '0;
      idx     <= '0;
      bus.seg <= SEG_BLANK;
      bus.dp  <= 1'b1;
      bus.an  <= 6'h3F;
    end else begin
      if (div == SCAN_DIV - 16'd1) begin
        div <= '0;
        idx <= (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
      end else begin
        div <= div + 16'd1;
      end
      bus.seg <= seg_dec;
      bus.dp  <= !(idx == 3'd1 || idx == 3'd3);
      bus.an  <= ~(6'b100000 >> idx);
    end
  end

endmodule

// File: tb/tb_watch_bcd_scan.sv
// tb/tb_watch_bcd_scan.sv - self-checking bench for watch_bcd_scan
module tb_watch_bcd_scan;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_err = 0;
  int   n_chk = 0;
  bit   cmp_en = 1'b0;

  watch_bcd_scan_if bus ();

  watch_bcd_scan #(.SCAN_DIV(16'd4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference behaviour: a countdown per conversion, decimal arithmetic on whole field values.
  int         m_cnt = 0;
  int         m_div = 0;
  int         m_idx = 0;
  bit         m_pend = 1'b1;
  int         m_snap [6];
  int         m_disp [6] = '{0, 0, 0, 0, 0, 0};
  logic [6:0] m_seg = 7'h7F;
  logic       m_dp = 1'b1;
  logic [5:0] m_an = 6'h3F;
  int         m_fv;
  int         m_dig;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_cnt = 0; m_pend = 1'b1; m_div = 0; m_idx = 0;
        for (int i = 0; i < 6; i++) m_disp[i] = 0;
        m_seg = 7'h7F; m_dp = 1'b1; m_an = 6'h3F;
      end else begin
        m_fv  = m_disp[(bus.page ? 3 : 0) + m_idx / 2];
        m_dig = (m_idx % 2 == 0) ? m_fv / 10 : m_fv % 10;
        m_seg = seg_of(m_dig);
        m_dp  = (m_idx == 1 || m_idx == 3) ? 1'b0 : 1'b1;
        m_an  = 6'h3F ^ (6'd1 << (5 - m_idx));
        if (m_div == DIV - 1) begin
          m_div = 0;
          m_idx = (m_idx + 1) % 6;
        end else begin
          m_div++;
        end
        if (m_cnt == 0) begin
          if (bus.clk1sec || m_pend) begin
            m_cnt  = 55;
            m_pend = 1'b0;
          end
        end else begin
          if (bus.clk1sec) m_pend = 1'b1;
          if (m_cnt == 55) begin
            m_snap[0] = bus.year;  m_snap[1] = bus.month;  m_snap[2] = bus.day;
            m_snap[3] = bus.hour;  m_snap[4] = bus.minute; m_snap[5] = bus.second;
          end
          if (m_cnt == 1)
            for (int i = 0; i < 6; i++) m_disp[i] = m_snap[i] % 100;
          m_cnt--;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("cyc_busy", bus.busy, (m_cnt != 0));
        chk("cyc_seg",  bus.seg,  m_seg);
        chk("cyc_dp",   bus.dp,   m_dp);
        chk("cyc_an",   bus.an,   m_an);
      end
    end
  end

  logic [6:0] cap_seg [6];
  logic       cap_dp  [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    bus.clk1sec = 1'b1;
    tick();
    bus.clk1sec = 1'b0;
  endtask

  task automatic capture(input int ncyc, output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 6; i++) begin cap_seg[i] = 7'h55; cap_dp[i] = 1'bx; end
    repeat (ncyc) begin
      tick();
      if (bus.busy === 1'b1) nbusy++;
      for (int p = 0; p < 6; p++)
        if (bus.an == (6'h3F ^ (6'd1 << p))) begin
          cap_seg[5 - p] = bus.seg;
          cap_dp[5 - p]  = bus.dp;
        end
    end
  endtask

  task automatic wait_rise(input string tag);
    int k = 0;
    while (bus.busy !== 1'b1 && k < 10) begin tick(); k++; end
    chk({tag, "_start"}, bus.busy, 1);
  endtask

  task automatic wait_fall(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin n++; tick(); end
  endtask

  task automatic rise_capture_fall(input string tag, output int total);
    int nb, nr;
    wait_rise(tag);
    total = (bus.busy === 1'b1) ? 1 : 0;
    capture(30, nb);
    total += nb;
    tick();
    wait_fall(nr);
    total += nr;
  endtask

  task automatic check_digits(input string tag, input logic [41:0] exp);
    for (int i = 0; i < 6; i++)
      chk($sformatf("%s_d%0d", tag, i), cap_seg[i], exp[41 - 7*i -: 7]);
  endtask

  task automatic sync_left(input string tag);
    int k = 0;
    while (bus.an !== 6'b111110 && k < 40) begin tick(); k++; end
    while (bus.an !== 6'b011111 && k < 80) begin tick(); k++; end
    chk({tag, "_sync"}, (k < 80), 1);
  endtask

  logic [41:0] e034;
  int n, nb;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.clk1sec = 1'b0; bus.page = 1'b0;
    bus.year = 8'd21; bus.month = 8'd5; bus.day = 8'd30;
    bus.hour = 8'd0;  bus.minute = 8'd0; bus.second = 8'd0;
    repeat (2) tick();
    cmp_en = 1'b1;
    chk("rst_seg",  bus.seg,  7'h7F);
    chk("rst_dp",   bus.dp,   1'b1);
    chk("rst_an",   bus.an,   6'h3F);
    chk("rst_busy", bus.busy, 1'b0);

    rst = 1'b0;
    wait_rise("r033");
    wait_fall(n);
    chk("r033_busy_len", n, 55);
    repeat (2) tick();
    capture(30, nb);
    check_digits("r033", {7'h24, 7'h79, 7'h40, 7'h12, 7'h30, 7'h40});
    for (int i = 0; i < 6; i++)
      chk($sformatf("r033_dp%0d", i), cap_dp[i], (i == 1 || i == 3) ? 1'b0 : 1'b1);

    bus.page = 1'b1; bus.hour = 8'd23; bus.minute = 8'd59; bus.second = 8'd59;
    pulse();
    wait_fall(n);
    chk("r034_busy_len", n, 55);
    sync_left("r034");
    e034 = {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10};
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < DIV; j++) begin
        chk($sformatf("r034_an%0d_%0d", i, j), bus.an, 6'h3F ^ (6'b100000 >> i));
        chk($sformatf("r034_seg%0d_%0d", i, j), bus.seg, e034[41 - 7*i -: 7]);
        tick();
      end

    bus.page = 1'b0; bus.year = 8'd255;
    pulse();
    wait_fall(n);
    capture(30, nb);
    chk("r035_d0", cap_seg[0], 7'h12);
    chk("r035_d1", cap_seg[1], 7'h12);

    bus.year = 8'd10; bus.month = 8'd11; bus.day = 8'd12;
    pulse();
    tick();
    bus.year = 8'd33; bus.month = 8'd44; bus.day = 8'd55;
    repeat (3) begin pulse(); tick(); end
    wait_fall(n);
    rise_capture_fall("r036", n);
    chk("r036_rerun_len", n, 55);
    check_digits("r036a", {7'h79, 7'h40, 7'h79, 7'h79, 7'h79, 7'h24});
    capture(30, nb);
    chk("r036_no_third", nb, 0);
    check_digits("r036b", {7'h30, 7'h30, 7'h19, 7'h19, 7'h12, 7'h12});

    bus.year = 8'd47; bus.month = 8'd8; bus.day = 8'd19;
    bus.hour = 8'd6;  bus.minute = 8'd34; bus.second = 8'd12;
    pulse();
    repeat (19) tick();
    rst = 1'b1;
    #1;
    chk("r037_seg", bus.seg, 7'h7F);
    chk("r037_an",  bus.an,  6'h3F);
    chk("r037_busy", bus.busy, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    rise_capture_fall("r037", n);
    chk("r037_rerun_len", n, 55);
    check_digits("r037z", {6{7'h40}});
    capture(30, nb);
    chk("r037_y0", cap_seg[0], 7'h19);
    chk("r037_y1", cap_seg[1], 7'h78);

    sync_left("r038");
    tick();
    chk("r038_before", bus.seg, 7'h19);
    bus.page = 1'b1;
    tick();
    chk("r038_an",    bus.an,  6'b011111);
    chk("r038_after", bus.seg, 7'h40);
    bus.page = 1'b0;
    repeat (4) tick();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
